// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: instruction-fetch stage of the 5-stage pipeline.
// Holds the program counter and the IF/ID pipeline register, applies the
// stall/flush/redirect controls from hazard detection and execute, and keeps
// saturating stall and flush event counters.
`timescale 1ns/1ps
module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pcwrite,
    input  logic             ifid_write,
    input  logic             ifid_flush,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      imem_instr,
    input  logic             cnt_clr,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_pc_o,
    output logic [31:0]      ifid_pc4_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_q,        pc_d;
    logic [31:0]      ifid_pc_q,   ifid_pc_d;
    logic [31:0]      ifid_pc4_q,  ifid_pc4_d;
    logic [31:0]      ifid_instr_q, ifid_instr_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_evt_s;

    // A stall cycle is one where the PC is held and no redirect overrides it.
    assign stall_evt_s = ~pcwrite & ~branch_taken;

    // Next PC: a redirect wins over a stall; sequential advance wraps modulo 2^32.
    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = {branch_target[31:2], 2'b00};
        end else if (pcwrite) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end
    end

    // Next IF/ID contents: flush inserts a bubble even when the register is held.
    always_comb begin
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (ifid_flush) begin
            ifid_pc_d    = 32'h0000_0000;
            ifid_pc4_d   = 32'h0000_0000;
            ifid_instr_d = 32'h0000_0000;
            ifid_valid_d = 1'b0;
        end else if (ifid_write) begin
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_q + 32'd4;
            ifid_instr_d = imem_instr;
            ifid_valid_d = 1'b1;
        end else begin
            ifid_pc_d    = ifid_pc_q;
            ifid_pc4_d   = ifid_pc4_q;
            ifid_instr_d = ifid_instr_q;
            ifid_valid_d = ifid_valid_q;
        end
    end

    // Next event counters: clear beats increment, increments saturate at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = CNT_ZERO;
            flush_cnt_d = CNT_ZERO;
        end else begin
            if (stall_evt_s && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (ifid_flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // State registers; reset clears everything immediately, discarding pending events.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_pc4_q   <= 32'h0000_0000;
            ifid_instr_q <= 32'h0000_0000;
            ifid_valid_q <= 1'b0;
            stall_cnt_q  <= CNT_ZERO;
            flush_cnt_q  <= CNT_ZERO;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign pc_o         = pc_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_valid_o = ifid_valid_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed, table-driven bench for fetch_stage_ctrl (instantiated with CNT_W=4
// so counter saturation is reachable in a short run).
`timescale 1ns/1ps
module tb_fetch_stage_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          pcwrite;
    logic          ifid_write;
    logic          ifid_flush;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic [31:0]   imem_instr;
    logic          cnt_clr;
    logic [31:0]   pc;
    logic [31:0]   ifid_pc;
    logic [31:0]   ifid_pc4;
    logic [31:0]   ifid_instr;
    logic          ifid_valid;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    fetch_stage_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .pcwrite       (pcwrite),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_instr    (imem_instr),
        .cnt_clr       (cnt_clr),
        .pc_o          (pc),
        .ifid_pc_o     (ifid_pc),
        .ifid_pc4_o    (ifid_pc4),
        .ifid_instr_o  (ifid_instr),
        .ifid_valid_o  (ifid_valid),
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt)
    );

    // Instruction memory model: word at address A is 0x2000_0000 + A.
    assign imem_instr = 32'h2000_0000 + pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pw;
        logic        iw;
        logic        fl;
        logic        br;
        logic [31:0] tgt;
        logic        clr;
        logic [31:0] e_pc;
        logic [31:0] e_ipc;
        logic [31:0] e_instr;
        logic        e_valid;
        int          e_stall;
        int          e_flush;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    function automatic vec_t mk(logic pw, logic iw, logic fl, logic br, logic [31:0] tgt,
                                logic clr, logic [31:0] e_pc, logic [31:0] e_ipc,
                                logic [31:0] e_instr, logic e_valid, int e_stall, int e_flush);
        vec_t v;
        v.pw = pw; v.iw = iw; v.fl = fl; v.br = br; v.tgt = tgt; v.clr = clr;
        v.e_pc = e_pc; v.e_ipc = e_ipc; v.e_instr = e_instr; v.e_valid = e_valid;
        v.e_stall = e_stall; v.e_flush = e_flush;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                           input logic [31:0] e_instr, input logic e_valid,
                           input int e_stall, input int e_flush);
        logic [31:0] e_pc4;
        e_pc4 = e_valid ? (e_ipc + 32'd4) : 32'h0000_0000;
        chk({tag, ".pc"},       pc,                   e_pc);
        chk({tag, ".ifid_pc"},  ifid_pc,              e_ipc);
        chk({tag, ".ifid_pc4"}, ifid_pc4,             e_pc4);
        chk({tag, ".instr"},    ifid_instr,           e_instr);
        chk({tag, ".valid"},    {31'd0, ifid_valid},  {31'd0, e_valid});
        chk({tag, ".stall"},    {28'd0, stall_cnt},   e_stall);
        chk({tag, ".flush"},    {28'd0, flush_cnt},   e_flush);
    endtask

    task automatic drive(input logic pw, input logic iw, input logic fl, input logic br,
                         input logic [31:0] tgt, input logic clr);
        pcwrite = pw; ifid_write = iw; ifid_flush = fl;
        branch_taken = br; branch_target = tgt; cnt_clr = clr;
    endtask

    // Apply current inputs across one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Sequential fetch, load-use stall at 0x10, branch+flush, branch during stall,
        // inconsistent controls, PC wrap, counter clear in a stall cycle.
        vecs[0]  = mk(1,1,0,0,32'h0,0, 32'h004, 32'h000, 32'h2000_0000, 1, 0, 0);
        vecs[1]  = mk(1,1,0,0,32'h0,0, 32'h008, 32'h004, 32'h2000_0004, 1, 0, 0);
        vecs[2]  = mk(1,1,0,0,32'h0,0, 32'h00C, 32'h008, 32'h2000_0008, 1, 0, 0);
        vecs[3]  = mk(1,1,0,0,32'h0,0, 32'h010, 32'h00C, 32'h2000_000C, 1, 0, 0);
        vecs[4]  = mk(0,0,0,0,32'h0,0, 32'h010, 32'h00C, 32'h2000_000C, 1, 1, 0);
        vecs[5]  = mk(0,0,0,0,32'h0,0, 32'h010, 32'h00C, 32'h2000_000C, 1, 2, 0);
        vecs[6]  = mk(1,1,0,0,32'h0,0, 32'h014, 32'h010, 32'h2000_0010, 1, 2, 0);
        vecs[7]  = mk(1,1,1,1,32'h103,0, 32'h100, 32'h000, 32'h0000_0000, 0, 2, 1);
        vecs[8]  = mk(1,1,0,0,32'h0,0, 32'h104, 32'h100, 32'h2000_0100, 1, 2, 1);
        vecs[9]  = mk(0,0,1,1,32'h201,0, 32'h200, 32'h000, 32'h0000_0000, 0, 2, 2);
        vecs[10] = mk(1,1,0,0,32'h0,0, 32'h204, 32'h200, 32'h2000_0200, 1, 2, 2);
        vecs[11] = mk(1,0,0,0,32'h0,0, 32'h208, 32'h200, 32'h2000_0200, 1, 2, 2);
        vecs[12] = mk(0,1,0,0,32'h0,0, 32'h208, 32'h208, 32'h2000_0208, 1, 3, 2);
        vecs[13] = mk(1,0,1,0,32'h0,0, 32'h20C, 32'h000, 32'h0000_0000, 0, 3, 3);
        vecs[14] = mk(1,1,0,1,32'hFFFF_FFFE,0, 32'hFFFF_FFFC, 32'h20C, 32'h2000_020C, 1, 3, 3);
        vecs[15] = mk(1,1,0,0,32'h0,0, 32'h000, 32'hFFFF_FFFC, 32'h1FFF_FFFC, 1, 3, 3);
        vecs[16] = mk(0,0,0,0,32'h0,1, 32'h000, 32'hFFFF_FFFC, 32'h1FFF_FFFC, 1, 0, 0);

        drive(0, 0, 0, 0, 32'h0, 0);
        rst_n = 1'b0;
        #23;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].br, vecs[i].tgt, vecs[i].clr);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ipc, vecs[i].e_instr,
                    vecs[i].e_valid, vecs[i].e_stall, vecs[i].e_flush);
        end

        // Stall 20 cycles: counter saturates at 15, PC and IF/ID stay frozen.
        drive(0, 0, 0, 0, 32'h0, 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 14) chk("stall_at_15", {28'd0, stall_cnt}, 32'd15);
        end
        chk_all("sat", 32'h0, 32'hFFFF_FFFC, 32'h1FFF_FFFC, 1'b1, 15, 0);

        // Flush saturation check on the second counter, with stall held.
        drive(0, 0, 1, 0, 32'h0, 0);
        for (int k = 0; k < 17; k++) tick();
        chk_all("fsat", 32'h0, 32'h0, 32'h0, 1'b0, 15, 15);

        // Clear while a stall and a flush are both still requesting increments.
        drive(0, 0, 1, 0, 32'h0, 1);
        tick();
        chk("clr.stall", {28'd0, stall_cnt}, 32'd0);
        chk("clr.flush", {28'd0, flush_cnt}, 32'd0);

        // Resume fetch from 0, then stall and hit reset between edges.
        drive(1, 1, 0, 0, 32'h0, 0);
        tick();
        tick();
        chk_all("resume", 32'h008, 32'h004, 32'h2000_0004, 1'b1, 0, 0);
        drive(0, 0, 0, 0, 32'h0, 0);
        tick();
        chk("stall1", {28'd0, stall_cnt}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("midrst", 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
        tick();
        chk_all("midrst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
        #2;
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 32'h0, 0);
        tick();
        chk_all("post_rst", 32'h004, 32'h000, 32'h2000_0000, 1'b1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage_ctrl.md
# fetch_stage_ctrl

Instruction-fetch stage of the 5-stage pipelined CPU. It holds the program counter and the IF/ID pipeline register. It consumes the stall/flush controls produced by hazard detection (`pcwrite`, `ifid_write`, `ifid_flush`) and the branch redirect from the execute stage. It also keeps saturating stall and flush event counters that the lab testbench reads.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `CNT_W`, 16, width of each event counter.

Ports:
- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_i` input 1: asynchronous, active-low reset.
- `pcwrite` input 1: 1 lets the PC advance; 0 holds it (load-use stall).
- `ifid_write` input 1: 1 lets IF/ID capture; 0 holds it.
- `ifid_flush` input 1: 1 replaces the IF/ID contents with a bubble.
- `branch_taken` input 1: redirects the PC to `branch_target`.
- `branch_target` input 32: redirect address; bits [1:0] are ignored and forced to 0.
- `imem_instr` input 32: instruction word from the combinational instruction memory at `pc_o`.
- `cnt_clr` input 1: synchronous clear of both counters.
- `pc_o` output 32: current fetch PC, registered.
- `ifid_pc_o` output 32: PC of the instruction held in IF/ID.
- `ifid_pc4_o` output 32: `ifid_pc_o` + 4.
- `ifid_instr_o` output 32: instruction held in IF/ID; 32'h0000_0000 (nop) when it is a bubble.
- `ifid_valid_o` output 1: 1 when IF/ID holds a real instruction.
- `stall_cnt_o` output CNT_W: number of stall cycles.
- `flush_cnt_o` output CNT_W: number of flush cycles.

## Operation
- **Reset** (`rst_i`=0, asynchronous): `pc_o`=RESET_PC. `ifid_pc_o`, `ifid_pc4_o`, `ifid_instr_o`, `ifid_valid_o`, `stall_cnt_o` and `flush_cnt_o` are all 0. Reset may assert mid-stall or mid-flush; state clears immediately and all pending events are discarded.
- **PC update**, in priority order:
  1. `branch_taken`=1: `pc_o` <= {branch_target[31:2], 2'b00}. This applies regardless of `pcwrite`, so a branch overrides a simultaneous load-use stall.
  2. `pcwrite`=1: `pc_o` <= `pc_o` + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  3. Otherwise `pc_o` holds.
- **IF/ID update**, in priority order:
  1. `ifid_flush`=1: `ifid_instr_o`<=0, `ifid_valid_o`<=0, `ifid_pc_o`<=0, `ifid_pc4_o`<=0. Flush beats `ifid_write`=0.
  2. `ifid_write`=1: `ifid_instr_o`<=`imem_instr`, `ifid_pc_o`<=`pc_o`, `ifid_pc4_o`<=`pc_o`+4, `ifid_valid_o`<=1.
  3. Otherwise all IF/ID fields hold.
- **Counters**:
  - `stall_cnt_o` increments on each edge where `pcwrite`=0 and `branch_taken`=0.
  - `flush_cnt_o` increments on each edge where `ifid_flush`=1.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
  - `cnt_clr`=1 forces both counters to 0 and takes priority over an increment in the same cycle.
- The block has no internal FSM beyond these registers. Combinations of inputs that are inconsistent (for example `ifid_write`=0 while `pcwrite`=1) are still honored literally, field by field.

## Timing
- `pc_o` is a registered output. `imem_instr` must be valid within the same cycle as `pc_o` and is sampled at the next rising edge.
- Fetch latency: the instruction at PC X appears on `ifid_instr_o` one edge after `pc_o`=X.
- Branch redirect: with `branch_taken`=1 in cycle N, `pc_o`=target in N+1 and the target's instruction is in IF/ID in N+2. A flush asserted in N leaves a bubble in IF/ID during N+1.
- Stall: with `pcwrite`=`ifid_write`=0 for k cycles, `pc_o` and IF/ID are frozen for exactly k cycles, and `stall_cnt_o` rises by k.
- After reset release, the first real instruction is valid in IF/ID one edge later (`ifid_valid_o`=1, `ifid_pc_o`=RESET_PC).

## Test plan
- **Sequential fetch.** Reset, then hold `pcwrite`=`ifid_write`=1 with the memory returning 32'h2000_0000+PC. Required: `pc_o`=0,4,8,…, `ifid_instr_o` lags by one cycle, `ifid_pc4_o`=`ifid_pc_o`+4.
- **Load-use stall.** Drop `pcwrite`=`ifid_write`=0 for 2 cycles at PC=0x10. Required: `pc_o` stays 0x10 for those cycles, IF/ID frozen at PC 0xC, then fetch resumes at 0x14; `stall_cnt_o`=2.
- **Branch with flush.** Assert `branch_taken`=1, `branch_target`=0x103, `ifid_flush`=1 for one cycle. Required: `pc_o`=0x100, next IF/ID is a bubble (`ifid_valid_o`=0, instr 0), the following cycle holds PC 0x100; `flush_cnt_o`=1.
- **Branch during stall.** Assert `branch_taken`=1 together with `pcwrite`=0, `ifid_write`=0, `ifid_flush`=1. Required: `pc_o`=target, IF/ID is a bubble, `stall_cnt_o` unchanged.
- **Wrap and saturation.** Force PC to 0xFFFF_FFFC and advance: `pc_o` becomes 0. With CNT_W=4, stall for 20 cycles: `stall_cnt_o`=15. Pulse `cnt_clr` in a stall cycle: the counter reads 0.
- **Mid-operation reset.** Drop `rst_i` asynchronously between clock edges during a stall. Required: all outputs reach their reset values immediately, and `pc_o`=RESET_PC.
